// File: rtl/dac_write_sched.sv
// Write scheduler for the 16-bit loop-control DAC behind a shared single-CS SPI master.
// Arbitrates boot/manual/loop writers, clamps the word, sends MSB then LSB, and enforces a CS-idle gap.
module dac_write_sched #(
    parameter logic [15:0] DAC_INIT = 16'h9E23,
    parameter logic [15:0] DAC_MIN  = 16'h0400,
    parameter logic [15:0] DAC_MAX  = 16'hFBFF,
    parameter int unsigned GAP_CYC  = 550
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        loop_req,
    input  logic [15:0] loop_val,
    output logic        loop_ack,
    input  logic        man_req,
    input  logic [15:0] man_val,
    output logic        man_ack,
    input  logic        spi_ready,
    output logic [7:0]  spi_byte,
    output logic        spi_dv,
    output logic        busy,
    output logic [15:0] dac_val,
    output logic        wr_done,
    output logic [15:0] wr_count,
    output logic [7:0]  clamp_count
);

    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_HI,
        S_WAIT_HI,
        S_SEND_LO,
        S_WAIT_LO,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic          boot_pend_q, boot_pend_d;
    logic [15:0]   word_q, word_d;
    logic          first_q, first_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          busy_q, busy_d;
    logic          wr_done_q, wr_done_d;
    logic [15:0]   dac_val_q, dac_val_d;
    logic [15:0]   wr_count_q, wr_count_d;
    logic [7:0]    clamp_count_q, clamp_count_d;
    logic          grant_user;
    logic [15:0]   grant_val;

    function automatic logic [15:0] clamp_word(input logic [15:0] v);
        if (v < DAC_MIN)
            return DAC_MIN;
        else if (v > DAC_MAX)
            return DAC_MAX;
        else
            return v;
    endfunction

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            boot_pend_q   <= 1'b1;
            word_q        <= DAC_INIT;
            first_q       <= 1'b0;
            gap_cnt_q     <= '0;
            byte_q        <= 8'h00;
            busy_q        <= 1'b0;
            wr_done_q     <= 1'b0;
            dac_val_q     <= DAC_INIT;
            wr_count_q    <= 16'h0000;
            clamp_count_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            boot_pend_q   <= boot_pend_d;
            word_q        <= word_d;
            first_q       <= first_d;
            gap_cnt_q     <= gap_cnt_d;
            byte_q        <= byte_d;
            busy_q        <= busy_d;
            wr_done_q     <= wr_done_d;
            dac_val_q     <= dac_val_d;
            wr_count_q    <= wr_count_d;
            clamp_count_q <= clamp_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        boot_pend_d   = boot_pend_q;
        word_d        = word_q;
        first_d       = first_q;
        gap_cnt_d     = gap_cnt_q;
        byte_d        = byte_q;
        busy_d        = busy_q;
        wr_done_d     = 1'b0;
        dac_val_d     = dac_val_q;
        wr_count_d    = wr_count_q;
        clamp_count_d = clamp_count_q;
        grant_user    = 1'b0;
        grant_val     = 16'h0000;
        man_ack       = 1'b0;
        loop_ack      = 1'b0;
        spi_dv        = 1'b0;
        spi_byte      = byte_q;

        case (state_q)
            S_IDLE: begin
                if (boot_pend_q) begin
                    boot_pend_d = 1'b0;
                    word_d      = DAC_INIT;
                end else if (man_req) begin
                    man_ack    = 1'b1;
                    grant_user = 1'b1;
                    grant_val  = man_val;
                end else if (loop_req) begin
                    loop_ack   = 1'b1;
                    grant_user = 1'b1;
                    grant_val  = loop_val;
                end
                if (grant_user) begin
                    word_d = clamp_word(grant_val);
                    if (word_d != grant_val && clamp_count_q != 8'hFF)
                        clamp_count_d = clamp_count_q + 8'd1;
                end
                if (boot_pend_q || grant_user) begin
                    busy_d  = 1'b1;
                    state_d = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (spi_ready) begin
                    spi_dv   = 1'b1;
                    spi_byte = word_q[15:8];
                    byte_d   = word_q[15:8];
                    first_d  = 1'b1;
                    state_d  = S_WAIT_HI;
                end
            end
            // The master drops ready one cycle after dv, so the first wait cycle is blind.
            S_WAIT_HI: begin
                first_d = 1'b0;
                if (!first_q && spi_ready)
                    state_d = S_SEND_LO;
            end
            S_SEND_LO: begin
                if (spi_ready) begin
                    spi_dv   = 1'b1;
                    spi_byte = word_q[7:0];
                    byte_d   = word_q[7:0];
                    first_d  = 1'b1;
                    state_d  = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                first_d = 1'b0;
                if (!first_q && spi_ready) begin
                    dac_val_d  = word_q;
                    wr_done_d  = 1'b1;
                    wr_count_d = wr_count_q + 16'd1;
                    gap_cnt_d  = '0;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = busy_q;
    assign wr_done     = wr_done_q;
    assign dac_val     = dac_val_q;
    assign wr_count    = wr_count_q;
    assign clamp_count = clamp_count_q;

endmodule

// File: tb/tb_dac_write_sched.sv
// Bench for dac_write_sched: directed corner sequences, a clamp vector table, and random traffic
// scored against a transaction-level model of grants, bytes, gap timing and counters.
module tb_dac_write_sched;

    localparam logic [15:0] DAC_INIT = 16'h9E23;
    localparam logic [15:0] DAC_MIN  = 16'h0400;
    localparam logic [15:0] DAC_MAX  = 16'hFBFF;
    localparam int          GAP_CYC  = 550;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        loop_req = 1'b0;
    logic [15:0] loop_val = 16'h0000;
    logic        loop_ack;
    logic        man_req = 1'b0;
    logic [15:0] man_val = 16'h0000;
    logic        man_ack;
    logic        spi_ready = 1'b1;
    logic [7:0]  spi_byte;
    logic        spi_dv;
    logic        busy;
    logic [15:0] dac_val;
    logic        wr_done;
    logic [15:0] wr_count;
    logic [7:0]  clamp_count;

    dac_write_sched #(
        .DAC_INIT(DAC_INIT),
        .DAC_MIN (DAC_MIN),
        .DAC_MAX (DAC_MAX),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .loop_req   (loop_req),
        .loop_val   (loop_val),
        .loop_ack   (loop_ack),
        .man_req    (man_req),
        .man_val    (man_val),
        .man_ack    (man_ack),
        .spi_ready  (spi_ready),
        .spi_byte   (spi_byte),
        .spi_dv     (spi_dv),
        .busy       (busy),
        .dac_val    (dac_val),
        .wr_done    (wr_done),
        .wr_count   (wr_count),
        .clamp_count(clamp_count)
    );

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL timeout %s: event not seen within bound (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] ref_clamp(input logic [15:0] v);
        return (v < DAC_MIN) ? DAC_MIN : ((v > DAC_MAX) ? DAC_MAX : v);
    endfunction

    // Reference model: the scheduler is free once GAP_CYC cycles have passed since wr_done
    // and no frame is in flight; a free cycle grants boot, then manual, then loop.
    bit          m_boot, m_in_frame, m_idle, m_exp_man, m_exp_loop;
    int          m_idle_from, byte_idx, m_clamp, last_done, frames_done, dv_count;
    int          frame_dv_cyc, man_ack_cyc, loop_ack_cyc;
    logic [15:0] m_dac, m_wr_count, m_w;
    logic [15:0] exp_q[$];
    logic [7:0]  m_last_byte, cur_hi, cur_lo, last_hi, last_lo;
    bit          dv_seen, man_ack_seen, loop_ack_seen;

    task automatic model_grant(input logic [15:0] v);
        logic [15:0] w;
        w = ref_clamp(v);
        if (w != v && m_clamp < 255)
            m_clamp++;
        exp_q.push_back(w);
        m_in_frame = 1'b1;
    endtask

    always @(negedge CLOCK_50) begin
        cyc++;
        dv_seen       = spi_dv;
        man_ack_seen  = man_ack;
        loop_ack_seen = loop_ack;
        if (man_ack)  man_ack_cyc  = cyc;
        if (loop_ack) loop_ack_cyc = cyc;
        if (reset) begin
            m_boot      = 1'b1;
            m_in_frame  = 1'b0;
            m_idle_from = 0;
            exp_q.delete();
            byte_idx    = 0;
            m_wr_count  = 16'h0000;
            m_clamp     = 0;
            m_dac       = DAC_INIT;
            m_last_byte = 8'h00;
            last_done   = -100000;
        end else begin
            m_idle = !m_in_frame && (cyc >= m_idle_from);
            chk("busy", 32'(busy), 32'(!m_idle));
            if (wr_done) begin
                chk("bytes_per_frame", 32'(byte_idx), 32'd2);
                if (exp_q.size() == 0)
                    chk("wr_done_without_frame", 32'd1, 32'd0);
                else begin
                    m_w   = exp_q.pop_front();
                    m_dac = m_w;
                end
                m_wr_count  = m_wr_count + 16'd1;
                m_in_frame  = 1'b0;
                m_idle_from = cyc + GAP_CYC;
                last_done   = cyc;
                byte_idx    = 0;
                last_hi     = cur_hi;
                last_lo     = cur_lo;
                frames_done++;
            end
            if (spi_dv) begin
                dv_count++;
                chk("dv_while_ready_low", 32'(spi_ready), 32'd1);
                if (exp_q.size() == 0 || byte_idx > 1)
                    chk("unexpected_dv", 32'd1, 32'd0);
                else begin
                    m_w = exp_q[0];
                    if (byte_idx == 0) begin
                        chk("byte_hi", 32'(spi_byte), 32'(m_w[15:8]));
                        chk("gap_spacing", 32'(cyc - last_done >= GAP_CYC + 1), 32'd1);
                        cur_hi       = spi_byte;
                        frame_dv_cyc = cyc;
                    end else begin
                        chk("byte_lo", 32'(spi_byte), 32'(m_w[7:0]));
                        cur_lo = spi_byte;
                    end
                    byte_idx++;
                end
                m_last_byte = spi_byte;
            end else begin
                chk("spi_byte_hold", 32'(spi_byte), 32'(m_last_byte));
            end
            chk("dac_val", 32'(dac_val), 32'(m_dac));
            chk("wr_count", 32'(wr_count), 32'(m_wr_count));
            chk("clamp_count", 32'(clamp_count), 32'(m_clamp));
            m_exp_man  = 1'b0;
            m_exp_loop = 1'b0;
            if (m_idle) begin
                if (m_boot) begin
                    m_boot = 1'b0;
                    exp_q.push_back(DAC_INIT);
                    m_in_frame = 1'b1;
                end else if (man_req) begin
                    m_exp_man = 1'b1;
                    model_grant(man_val);
                end else if (loop_req) begin
                    m_exp_loop = 1'b1;
                    model_grant(loop_val);
                end
            end
            chk("man_ack", 32'(man_ack), 32'(m_exp_man));
            chk("loop_ack", 32'(loop_ack), 32'(m_exp_loop));
        end
    end

    // SPI master stand-in: ready stays high one cycle after dv, then drops for 0..m_len cycles.
    int m_len = 0;
    bit force_low = 1'b0;
    bit m_late = 1'b0;
    int m_low = 0;
    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (m_late) begin
                m_late = 1'b0;
                m_low  = $urandom_range(0, m_len);
            end
            if (dv_seen) m_late = 1'b1;
            if (reset) begin
                m_late = 1'b0;
                m_low  = 0;
            end
            if (force_low)
                spi_ready = 1'b0;
            else if (m_low > 0) begin
                spi_ready = 1'b0;
                m_low--;
            end else
                spi_ready = 1'b1;
        end
    end

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge CLOCK_50);
            k++;
        end while (busy !== 1'b0 && k < 3000);
        if (busy !== 1'b0) timeout_fail("wait_idle");
    endtask

    task automatic wait_done(input int bound);
        int n0 = frames_done;
        int k = 0;
        while (frames_done == n0 && k < bound) begin
            @(negedge CLOCK_50);
            k++;
        end
        if (frames_done == n0) timeout_fail("wait_done");
    endtask

    task automatic request(input bit is_man, input logic [15:0] val);
        bit got = 1'b0;
        int k = 0;
        @(posedge CLOCK_50);
        #1;
        if (is_man) begin man_req = 1'b1; man_val = val; end
        else begin loop_req = 1'b1; loop_val = val; end
        while (!got && k < 3000) begin
            @(negedge CLOCK_50);
            k++;
            got = is_man ? man_ack : loop_ack;
        end
        if (!got) timeout_fail("request_ack");
        @(posedge CLOCK_50);
        #1;
        if (is_man) begin man_req = 1'b0; man_val = 16'hDEAD; end
        else begin loop_req = 1'b0; loop_val = 16'hBEEF; end
    endtask

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 16'h0500));
            1:       return 16'($urandom_range(16'hFB00, 16'hFFFF));
            default: return 16'($urandom_range(0, 16'hFFFF));
        endcase
    endfunction

    typedef struct {
        bit          is_man;
        logic [15:0] val;
        logic [15:0] exp_word;
        int          exp_clamp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit got_m, got_l;
        int k, d1, dv0;

        vecs[0] = '{1'b0, 16'h0010, 16'h0400, 1};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFBFF, 2};
        vecs[2] = '{1'b1, 16'h0400, 16'h0400, 2};
        vecs[3] = '{1'b1, 16'hFBFF, 16'hFBFF, 2};
        vecs[4] = '{1'b0, 16'h03FF, 16'h0400, 3};
        vecs[5] = '{1'b1, 16'hFC00, 16'hFBFF, 4};
        vecs[6] = '{1'b0, 16'h1234, 16'h1234, 4};

        // Reset values, then the automatic boot frame
        m_len = 0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_spi_dv", 32'(spi_dv), 32'd0);
        chk("rst_spi_byte", 32'(spi_byte), 32'd0);
        chk("rst_acks", 32'({man_ack, loop_ack}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_done", 32'(wr_done), 32'd0);
        chk("rst_dac_val", 32'(dac_val), 32'(DAC_INIT));
        chk("rst_counts", 32'({wr_count, clamp_count}), 32'd0);
        reset = 1'b0;
        wait_done(100);
        chk("t1_bytes", 32'({last_hi, last_lo}), 32'h9E23);
        chk("t1_dac_val", 32'(dac_val), 32'h9E23);
        chk("t1_wr_count", 32'(wr_count), 32'd1);

        // Single loop write and grant-to-dv latency
        wait_idle();
        request(1'b0, 16'h8000);
        wait_done(200);
        chk("t2_bytes", 32'({last_hi, last_lo}), 32'h8000);
        chk("t2_dac_val", 32'(dac_val), 32'h8000);
        chk("t2_latency", 32'(frame_dv_cyc - loop_ack_cyc), 32'd1);

        // Simultaneous requests: manual first, loop served after the gap
        wait_idle();
        @(posedge CLOCK_50);
        #1;
        man_req = 1'b1; man_val = 16'h1234;
        loop_req = 1'b1; loop_val = 16'h5678;
        got_m = 1'b0; got_l = 1'b0; k = 0;
        while (!(got_m && got_l) && k < 3000) begin
            @(negedge CLOCK_50);
            k++;
            if (man_ack) got_m = 1'b1;
            if (loop_ack) got_l = 1'b1;
            @(posedge CLOCK_50);
            #1;
            if (got_m) man_req = 1'b0;
            if (got_l) loop_req = 1'b0;
        end
        if (!(got_m && got_l)) timeout_fail("t3_acks");
        chk("t3_order", 32'(man_ack_cyc < loop_ack_cyc), 32'd1);
        chk("t3_first_word", 32'({last_hi, last_lo}), 32'h1234);
        d1 = last_done;
        wait_done(200);
        chk("t3_second_word", 32'({last_hi, last_lo}), 32'h5678);
        chk("t3_spacing", 32'(frame_dv_cyc - d1 >= GAP_CYC + 1), 32'd1);

        // Clamp table, including both inclusive bounds
        for (int i = 0; i < 7; i++) begin
            wait_idle();
            request(vecs[i].is_man, vecs[i].val);
            wait_done(200);
            chk($sformatf("t4_word[%0d]", i), 32'({last_hi, last_lo}), 32'(vecs[i].exp_word));
            chk($sformatf("t4_dac_val[%0d]", i), 32'(dac_val), 32'(vecs[i].exp_word));
            chk($sformatf("t4_clamp_count[%0d]", i), 32'(clamp_count), 32'(vecs[i].exp_clamp));
        end

        // Ready held low for 100 cycles while the LSB is pending
        wait_idle();
        request(1'b1, 16'hA55A);
        @(negedge CLOCK_50);
        chk("t5_hi_dv", 32'(spi_dv), 32'd1);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        force_low = 1'b1;
        dv0 = dv_count;
        repeat (100) @(negedge CLOCK_50);
        chk("t5_no_dv_stalled", 32'(dv_count), 32'(dv0));
        chk("t5_busy_stalled", 32'(busy), 32'd1);
        force_low = 1'b0;
        wait_done(50);
        chk("t5_lo_once", 32'(dv_count), 32'(dv0 + 1));
        chk("t5_dac_val", 32'(dac_val), 32'hA55A);

        // Random traffic with held, withdrawn and value-changing requests
        m_len = 5;
        for (int c = 0; c < 20000; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (man_req && man_ack_seen) man_req = 1'b0;
            else if (man_req && $urandom_range(0, 299) == 0) man_req = 1'b0;
            else if (!man_req && $urandom_range(0, 79) == 0) begin
                man_req = 1'b1; man_val = rand_val();
            end else if (man_req && $urandom_range(0, 9) == 0) man_val = rand_val();
            if (loop_req && loop_ack_seen) loop_req = 1'b0;
            else if (loop_req && $urandom_range(0, 299) == 0) loop_req = 1'b0;
            else if (!loop_req && $urandom_range(0, 39) == 0) begin
                loop_req = 1'b1; loop_val = rand_val();
            end else if (loop_req && $urandom_range(0, 9) == 0) loop_val = rand_val();
        end
        @(posedge CLOCK_50);
        #1;
        man_req = 1'b0;
        loop_req = 1'b0;
        wait_idle();
        chk("rand_frames_seen", 32'(frames_done > 20), 32'd1);

        // Reset during the boot frame's MSB dv, then the boot word is re-sent
        m_len = 0;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        k = 0;
        do begin
            @(negedge CLOCK_50);
            k++;
        end while (!spi_dv && k < 10);
        if (!spi_dv) timeout_fail("t6_hi_dv");
        #2;
        reset = 1'b1;
        #1;
        chk("t6_dv_drop", 32'(spi_dv), 32'd0);
        chk("t6_dac_val", 32'(dac_val), 32'h9E23);
        chk("t6_wr_done", 32'(wr_done), 32'd0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        wait_done(100);
        chk("t6_bytes", 32'({last_hi, last_lo}), 32'h9E23);
        chk("t6_wr_count", 32'(wr_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1800000;
        n_errors++;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
